// File: rtl/i2c_slave_regfile_if.sv
// Host-side register port of the I2C slave register file: preload writes in,
// per-byte write strobes and status out.
interface i2c_slave_regfile_if #(
  parameter int DATA_I2C_SZ = 8,
  parameter int REG_ADDR_SZ = 8
);
  logic                   I_WE;
  logic [REG_ADDR_SZ-1:0] I_WADDR;
  logic [DATA_I2C_SZ-1:0] I_WDATA;
  logic                   O_WR_STB;
  logic [REG_ADDR_SZ-1:0] O_WR_ADDR;
  logic [DATA_I2C_SZ-1:0] O_WR_DATA;
  logic                   O_BUSY;
  logic [4:0]             O_CNT_NACK;

  modport slave  (input  I_WE, I_WADDR, I_WDATA,
                  output O_WR_STB, O_WR_ADDR, O_WR_DATA, O_BUSY, O_CNT_NACK);
  modport master (output I_WE, I_WADDR, I_WDATA,
                  input  O_WR_STB, O_WR_ADDR, O_WR_DATA, O_BUSY, O_CNT_NACK);
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing a 2**REG_ADDR_SZ register file with an auto-incrementing
// pointer, a read-only WHOAMI register and a host preload port.
module i2c_slave_regfile #(
  parameter logic [6:0]             SLV_ADDR    = 7'h68,
  parameter int                     DATA_I2C_SZ = 8,
  parameter int                     REG_ADDR_SZ = 8,
  parameter logic [REG_ADDR_SZ-1:0] WHOAMI_ADDR = 8'h75
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic I_SCL,
  inout  wire  IO_SDA,
  i2c_slave_regfile_if.slave host
);
  localparam int CNT_W = $clog2(DATA_I2C_SZ + 1);
  localparam int DEPTH = 2**REG_ADDR_SZ;
  localparam logic [CNT_W-1:0] N_ADDR = CNT_W'(8);
  localparam logic [CNT_W-1:0] N_DATA = CNT_W'(DATA_I2C_SZ);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(DATA_I2C_SZ - 1);
  localparam logic [DATA_I2C_SZ-1:0] WHOAMI_VAL = DATA_I2C_SZ'({1'b0, SLV_ADDR});

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_P
  } state_e;

  state_e                 state_q;
  logic [2:0]             scl_q, sda_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_I2C_SZ-1:0] rx_q, tx_q;
  logic [REG_ADDR_SZ-1:0] ptr_q, wr_addr_q;
  logic [DATA_I2C_SZ-1:0] wr_data_q;
  logic                   rw_q, sda_oe_q, stb_q, busy_q;
  logic [4:0]             nack_q;
  logic [DATA_I2C_SZ-1:0] mem_q [DEPTH];

  // Synchronisers idle high so reset release never looks like a bus edge.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], I_SCL};
      sda_q <= {sda_q[1:0], IO_SDA};
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;
  assign sda_s     = sda_q[1];
  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  assign start_det =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_det  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];

  logic [REG_ADDR_SZ-1:0] ptr_inc;
  logic [DATA_I2C_SZ-1:0] rx_byte, rd_cur, rd_nxt;
  assign ptr_inc = ptr_q + REG_ADDR_SZ'(1);
  assign rx_byte = {rx_q[DATA_I2C_SZ-2:0], sda_s};
  assign rd_cur  = (ptr_q   == WHOAMI_ADDR) ? WHOAMI_VAL : mem_q[ptr_q];
  assign rd_nxt  = (ptr_inc == WHOAMI_ADDR) ? WHOAMI_VAL : mem_q[ptr_inc];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      stb_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      nack_q    <= '0;
      mem_q     <= '{default: '0};
    end else begin
      stb_q <= 1'b0;
      // Host write first so an I2C write to the same cell in this cycle overrides it.
      if (host.I_WE && host.I_WADDR != WHOAMI_ADDR) mem_q[host.I_WADDR] <= host.I_WDATA;

      if (start_det) begin
        state_q  <= ADDR;
        cnt_q    <= '0;
        sda_oe_q <= 1'b0;
      end else if (stop_det) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        if (scl_rise && (state_q == ADDR || state_q == PTR || state_q == WR || state_q == RD)) begin
          rx_q  <= rx_byte;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        case (state_q)
          ADDR: if (scl_fall && cnt_q == N_ADDR) begin
            cnt_q <= '0;
            rw_q  <= rx_q[0];
            if (rx_q[7:1] == SLV_ADDR) begin
              state_q  <= ADDR_ACK;
              sda_oe_q <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          ADDR_ACK: if (scl_fall) begin
            cnt_q <= '0;
            if (rw_q) begin
              tx_q     <= rd_cur;
              sda_oe_q <= ~rd_cur[DATA_I2C_SZ-1];
              state_q  <= RD;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= PTR;
            end
          end
          PTR: if (scl_fall && cnt_q == N_DATA) begin
            ptr_q    <= rx_q[REG_ADDR_SZ-1:0];
            sda_oe_q <= 1'b1;
            state_q  <= PTR_ACK;
          end
          PTR_ACK, WR_ACK: if (scl_fall) begin
            sda_oe_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= WR;
          end
          // Commit on the 8th rise rather than the ACK fall to keep strobe latency short.
          WR: if (scl_rise && cnt_q == N_LAST) begin
            stb_q     <= 1'b1;
            wr_addr_q <= ptr_q;
            wr_data_q <= rx_byte;
            if (ptr_q != WHOAMI_ADDR) mem_q[ptr_q] <= rx_byte;
            ptr_q     <= ptr_inc;
          end else if (scl_fall && cnt_q == N_DATA) begin
            sda_oe_q <= 1'b1;
            state_q  <= WR_ACK;
          end
          RD: if (scl_fall) begin
            if (cnt_q == N_DATA) begin
              sda_oe_q <= 1'b0;
              cnt_q    <= '0;
              state_q  <= RD_ACK;
            end else begin
              tx_q     <= tx_q << 1;
              sda_oe_q <= ~tx_q[DATA_I2C_SZ-2];
            end
          end
          RD_ACK: if (scl_rise && sda_s) begin
            if (nack_q != 5'd31) nack_q <= nack_q + 5'd1;
            busy_q  <= 1'b0;
            state_q <= WAIT_P;
          end else if (scl_fall) begin
            ptr_q    <= ptr_inc;
            tx_q     <= rd_nxt;
            sda_oe_q <= ~rd_nxt[DATA_I2C_SZ-1];
            cnt_q    <= '0;
            state_q  <= RD;
          end
          default: ;
        endcase
      end
    end
  end

  assign IO_SDA          = sda_oe_q ? 1'b0 : 1'bz;
  assign host.O_WR_STB   = stb_q;
  assign host.O_WR_ADDR  = wr_addr_q;
  assign host.O_WR_DATA  = wr_data_q;
  assign host.O_BUSY     = busy_q;
  assign host.O_CNT_NACK = nack_q;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bus-level bench for i2c_slave_regfile: bit-banged I2C master, host preload,
// scoreboard queues for read bytes and write strobes.
module tb_i2c_slave_regfile;
  localparam int Q = 5;  // CLK cycles per quarter SCL period

  logic CLK = 1'b0, RST_n = 1'b0, scl = 1'b1, m_low = 1'b0;
  wire  sda;
  int   n_chk = 0, n_err = 0, cyc = 0, t_rise = 0, exp_nack = 0;
  logic [15:0] stb_exp[$];
  logic [7:0]  rd_exp[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave_regfile_if #(.DATA_I2C_SZ(8), .REG_ADDR_SZ(8)) hif ();

  i2c_slave_regfile #(
    .SLV_ADDR(7'h68), .DATA_I2C_SZ(8), .REG_ADDR_SZ(8), .WHOAMI_ADDR(8'h75)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .I_SCL(scl), .IO_SDA(sda), .host(hif)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge scl) t_rise = cyc;

  always @(negedge CLK) begin
    if (RST_n && hif.O_WR_STB) begin
      chk("stb_lat", 32'(cyc - t_rise <= 4), 1);
      chk("stb_pending", 32'(stb_exp.size() > 0), 1);
      if (stb_exp.size() > 0) chk("stb_data", {hif.O_WR_ADDR, hif.O_WR_DATA}, stb_exp.pop_front());
    end
  end

  task automatic wq(input int n);
    repeat (n * Q) @(negedge CLK);
  endtask

  task automatic bitx(input logic b, output logic s);
    m_low = ~b; wq(1);
    scl = 1'b1; wq(1);
    s = sda;    wq(1);
    scl = 1'b0; wq(1);
  endtask

  task automatic i2c_start;
    m_low = 1'b0; wq(1); scl = 1'b1; wq(1); m_low = 1'b1; wq(1); scl = 1'b0; wq(1);
  endtask

  task automatic i2c_stop;
    m_low = 1'b1; wq(1); scl = 1'b1; wq(1); m_low = 1'b0; wq(2);
  endtask

  task automatic i2c_wr(input logic [7:0] b, input string tag, input logic exp_ack);
    logic s;
    for (int i = 7; i >= 0; i--) bitx(b[i], s);
    bitx(1'b1, s);
    chk(tag, s, exp_ack);
  endtask

  task automatic i2c_rd(input logic nack, input string tag);
    logic [7:0] b;
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bitx(1'b1, s);
      b[i] = s;
    end
    bitx(nack, s);
    if (nack && exp_nack < 31) exp_nack++;
    chk(tag, b, rd_exp.pop_front());
  endtask

  task automatic hw(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    hif.I_WE = 1'b1; hif.I_WADDR = a; hif.I_WDATA = d;
    @(negedge CLK);
    hif.I_WE = 1'b0;
  endtask

  task automatic set_ptr(input logic [7:0] p);
    i2c_start;
    i2c_wr(8'hD0, "aw", 1'b0);
    i2c_wr(p, "ptr", 1'b0);
  endtask

  task automatic rd_from(input logic [7:0] p, input logic [7:0] exp, input string tag);
    set_ptr(p);
    i2c_start;
    i2c_wr(8'hD1, "ar", 1'b0);
    rd_exp.push_back(exp);
    i2c_rd(1'b1, tag);
    i2c_stop;
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic s;
    hif.I_WE = 1'b0; hif.I_WADDR = '0; hif.I_WDATA = '0;
    repeat (4) @(negedge CLK);
    chk("rst_busy", hif.O_BUSY, 0);
    chk("rst_nack", hif.O_CNT_NACK, 0);
    chk("rst_stb", hif.O_WR_STB, 0);
    chk("rst_sda", sda, 1);
    RST_n = 1'b1; wq(2);

    // Preloaded sensor bytes read back with ACK then NACK
    hw(8'h3B, 8'hF0); hw(8'h3C, 8'hB0);
    set_ptr(8'h3B);
    i2c_start;
    i2c_wr(8'hD1, "ar_3b", 1'b0);
    chk("busy_on", hif.O_BUSY, 1);
    rd_exp.push_back(8'hF0); i2c_rd(1'b0, "rd_3b");
    rd_exp.push_back(8'hB0); i2c_rd(1'b1, "rd_3c");
    i2c_stop;
    chk("nack_cnt1", hif.O_CNT_NACK, exp_nack);
    chk("busy_off", hif.O_BUSY, 0);

    // Single I2C write over a host-preloaded value
    hw(8'h6B, 8'h55);
    set_ptr(8'h6B);
    stb_exp.push_back({8'h6B, 8'h00});
    i2c_wr(8'h00, "wd_6b", 1'b0);
    i2c_stop;
    rd_from(8'h6B, 8'h00, "rb_6b");

    // Burst write with pointer auto-increment
    set_ptr(8'h20);
    stb_exp.push_back({8'h20, 8'h01}); i2c_wr(8'h01, "wd_20", 1'b0);
    stb_exp.push_back({8'h21, 8'h02}); i2c_wr(8'h02, "wd_21", 1'b0);
    i2c_stop;
    set_ptr(8'h20);
    i2c_start;
    i2c_wr(8'hD1, "ar_20", 1'b0);
    rd_exp.push_back(8'h01); i2c_rd(1'b0, "rb_20");
    rd_exp.push_back(8'h02); i2c_rd(1'b1, "rb_21");
    i2c_stop;

    // WHOAMI is read-only from both sides
    rd_from(8'h75, 8'h68, "who");
    hw(8'h75, 8'h11);
    set_ptr(8'h75);
    stb_exp.push_back({8'h75, 8'hAA});
    i2c_wr(8'hAA, "wd_75", 1'b0);
    i2c_stop;
    rd_from(8'h75, 8'h68, "who_keep");

    // Foreign address: no ACK, never busy
    i2c_start;
    i2c_wr(8'hD2, "nak_69", 1'b1);
    chk("busy_69", hif.O_BUSY, 0);
    i2c_stop;

    // Pointer wrap FF -> 00 -> 01
    hw(8'hFF, 8'hA5); hw(8'h00, 8'h5A); hw(8'h01, 8'hC3);
    set_ptr(8'hFF);
    i2c_start;
    i2c_wr(8'hD1, "ar_ff", 1'b0);
    rd_exp.push_back(8'hA5); i2c_rd(1'b0, "rd_ff");
    rd_exp.push_back(8'h5A); i2c_rd(1'b0, "rd_00");
    rd_exp.push_back(8'hC3); i2c_rd(1'b1, "rd_01");
    i2c_stop;

    // Host writes mid-byte: current byte already latched, next byte sees the update
    hw(8'h10, 8'h11); hw(8'h11, 8'h22);
    set_ptr(8'h10);
    i2c_start;
    i2c_wr(8'hD1, "ar_10", 1'b0);
    rd_exp.push_back(8'h11); rd_exp.push_back(8'h77);
    fork
      i2c_rd(1'b0, "rd_latch");
      begin wq(10); hw(8'h10, 8'h99); hw(8'h11, 8'h77); end
    join
    i2c_rd(1'b1, "rd_next");
    i2c_stop;

    // Host keeps writing the same cell until the I2C write lands in the same cycle
    set_ptr(8'h30);
    stb_exp.push_back({8'h30, 8'hC5});
    fork
      i2c_wr(8'hC5, "wd_30", 1'b0);
      begin
        hif.I_WE = 1'b1; hif.I_WADDR = 8'h30; hif.I_WDATA = 8'h3C;
        for (int k = 0; k < 400 && !hif.O_WR_STB; k++) @(negedge CLK);
        hif.I_WE = 1'b0;
      end
    join
    i2c_stop;
    rd_from(8'h30, 8'hC5, "rb_30");

    // NACK counter saturation; NACK leaves the pointer at 30
    for (int n = 0; n < 32; n++) begin
      i2c_start;
      i2c_wr(8'hD1, "ar_sat", 1'b0);
      rd_exp.push_back(8'hC5);
      i2c_rd(1'b1, "rd_sat");
      i2c_stop;
    end
    chk("nack_sat", hif.O_CNT_NACK, exp_nack);

    // Reset while the slave drives a 0 data bit
    set_ptr(8'h6B);
    i2c_start;
    i2c_wr(8'hD1, "ar_rst", 1'b0);
    m_low = 1'b0; wq(1);
    chk("rd_drive", sda, 0);
    RST_n = 1'b0;
    #1;
    chk("rst_rel", sda, 1);
    exp_nack = 0;
    wq(1);
    chk("rst_nack2", hif.O_CNT_NACK, exp_nack);
    chk("rst_busy2", hif.O_BUSY, 0);
    RST_n = 1'b1; wq(1);
    for (int n = 0; n < 3; n++) begin
      bitx(1'b1, s);
      chk("ignore", s, 1);
    end
    i2c_start;
    i2c_wr(8'hD0, "aw_post", 1'b0);
    i2c_wr(8'h3B, "ptr_post", 1'b0);
    i2c_stop;
    rd_from(8'h3B, 8'h00, "rb_cleared");
    chk("nack_post", hif.O_CNT_NACK, exp_nack);

    wq(4);
    chk("stb_left", stb_exp.size(), 0);
    chk("rd_left", rd_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_slave_regfile.md
I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 SHALL have parameter SLV_ADDR, default 7'h68, the 7-bit device address it responds to.
REQ-002 SHALL have parameter DATA_I2C_SZ, default 8, the register and I2C data width.
REQ-003 SHALL have parameter REG_ADDR_SZ, default 8, the register pointer width; depth = 2**REG_ADDR_SZ.
REQ-004 SHALL have parameter WHOAMI_ADDR, default 8'h75, a read-only register whose value is {1'b0, SLV_ADDR}.
REQ-005 SHALL have port CLK, input, 1, system clock; one clock domain only.
REQ-006 SHALL have port RST_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port I_SCL, input, 1, I2C serial clock driven by the master.
REQ-008 SHALL have port IO_SDA, inout, 1, open-drain serial data; drives only 1'b0 or 1'bz.
REQ-009 SHALL have port I_WE, input, 1, host write strobe for preloading registers (sensor data).
REQ-010 SHALL have ports I_WADDR (input, REG_ADDR_SZ) and I_WDATA (input, DATA_I2C_SZ): the host write address and data.
REQ-011 SHALL have ports O_WR_STB (output, 1), O_WR_ADDR (output, REG_ADDR_SZ) and O_WR_DATA (output, DATA_I2C_SZ): a one-cycle strobe per byte the master writes, with that byte's register address and data.
REQ-012 SHALL have port O_BUSY, output, 1, high from an address-matched START until STOP or NACK exit.
REQ-013 SHALL have port O_CNT_NACK, output, 5, a saturating count of master NACKs on reads.

Function
REQ-014 SHALL synchronise I_SCL and IO_SDA through 2-flop synchronisers, with 1 added cycle for edge detection.
REQ-015 SHALL detect START as an SDA fall while SCL is high, and STOP as an SDA rise while SCL is high.
REQ-016 SHALL sample SDA on an SCL rise and change its own SDA drive only after an SCL fall.
REQ-017 SHALL implement FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_P.
REQ-018 SHALL go from any state to ADDR on START, including repeated START, and reset the bit counter.
REQ-019 SHALL go from any state to IDLE on STOP, release SDA, and clear O_BUSY.
REQ-020 ADDR: after 8 bits, SHALL go to ADDR_ACK and drive SDA=0 if addr==SLV_ADDR; otherwise SHALL go to IDLE with SDA released.
REQ-021 ADDR_ACK: if R/W=0, SHALL go to PTR; if R/W=1, SHALL load the byte at the pointer and go to RD.
REQ-022 PTR: the first written byte after addr+W SHALL be the register pointer; SHALL ACK it and go to PTR_ACK, then WR.
REQ-023 WR: each byte SHALL be ACKed and written to reg[ptr] except WHOAMI_ADDR, which is ACKed but not written; SHALL pulse O_WR_STB, then increment ptr.
REQ-024 RD: SHALL shift MSB first; at RD_ACK, master ACK (0) SHALL increment ptr, load the next byte and go to RD.
REQ-025 RD_ACK: master NACK (1) SHALL increment O_CNT_NACK, saturating at 31, and go to WAIT_P.
REQ-026 The pointer SHALL wrap from 2**REG_ADDR_SZ-1 to 0.
REQ-027 The pointer SHALL persist across transactions, so addr+W,ptr then Sr,addr+R reads from ptr.
REQ-028 If the host write and an I2C write hit the same address in the same cycle, the I2C write SHALL win; host writes to WHOAMI_ADDR SHALL be ignored.
REQ-029 The read byte SHALL be latched when the byte starts; a host write during the byte SHALL affect the next read only.
REQ-030 O_WR_STB SHALL assert within 4 CLK after the SCL rise of the 8th data bit.

Reset
REQ-031 On RST_n=0, SHALL asynchronously set FSM=IDLE, SDA=z, ptr=0, all registers=0 except WHOAMI, O_WR_STB=0, O_WR_ADDR=0, O_WR_DATA=0, O_BUSY=0, O_CNT_NACK=0.
REQ-032 Reset asserted mid-transaction SHALL release SDA immediately; after release, the block SHALL ignore bus activity until the next START.

Verification
REQ-033 Write 68W,6B,00 -> 3 ACKs; O_WR_STB once with addr 6B, data 00; reg[6B]=00.
REQ-034 Host preload 3B=F0, 3C=B0; then 68W,3B,Sr,68R, ACK, NACK -> reads F0,B0; O_CNT_NACK=1.
REQ-035 68W,75,Sr,68R, NACK -> reads 68; write 68W,75,AA -> ACKed; reg[75] stays 68.
REQ-036 Address 69W -> no ACK (SDA=z at the 9th clock); O_BUSY stays 0; FSM stays IDLE.
REQ-037 Pointer FF, read 3 bytes with ACK,ACK,NACK -> reg[FF], reg[00], reg[01].
REQ-038 Assert RST_n mid-RD -> SDA released in the same cycle; next 68W transaction is ACKed normally.
